bfa_serial_adder: RTL and testbench

//  Bit-serial WIDTH-bit adder built around one BFA full-adder cell (I[1:0], ci, so, co).

---
 rtl/bfa_serial_adder.sv | 110 +++++++++++
 tb/tb_bfa_serial_adder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bfa_serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder cell consumes an operand bit pair per clock,
// LSB first, with a start/done handshake and registered outputs.
module bfa_serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned CntW = $clog2(WIDTH);
    localparam logic [CntW-1:0] LastBit = CntW'(WIDTH - 1);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, s_q, s_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             cout_q, cout_d;

    // Full-adder cell fed by the operand shift register LSBs and the carry flop.
    logic [1:0] bfa_in;
    logic       so, co;

    assign bfa_in = {b_q[0], a_q[0]};
    assign so     = bfa_in[0] ^ bfa_in[1] ^ carry_q;
    assign co     = (bfa_in[0] & bfa_in[1]) | (carry_q & (bfa_in[0] | bfa_in[1]));

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    carry_d = cin;
                    cnt_d   = '0;
                    s_d     = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                s_d     = {so, s_q[WIDTH-1:1]};
                carry_d = co;
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                cnt_d   = cnt_q + CntW'(1);
                if (cnt_q == LastBit) begin
                    sum_d   = {so, s_q[WIDTH-1:1]};
                    cout_d  = co;
                    done_d  = 1'b1;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d == StRun);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_bfa_serial_adder.sv
// Directed bench for bfa_serial_adder: an 8-bit instance for handshake, carry, overlap and
// reset scenarios, and a 2-bit instance swept exhaustively back-to-back.
module tb_bfa_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start, cin, busy, done, cout;
    logic [7:0] a, b, sum;
    logic       start2, cin2, busy2, done2, cout2;
    logic [1:0] a2, b2, sum2;

    int checks = 0;
    int errors = 0;

    bfa_serial_adder #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    bfa_serial_adder #(.WIDTH(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Accepts one 8-bit operation and waits (bounded) for its done pulse.
    // ok goes low if busy drops or sum/cout move before completion.
    task automatic run8(input logic [7:0] ia, input logic [7:0] ib, input logic ic,
                        output int edges, output logic [7:0] s, output logic c,
                        output logic ok);
        logic [7:0] s0;
        logic       c0;
        a = ia; b = ib; cin = ic; start = 1'b1;
        s0 = sum; c0 = cout;
        step();
        start = 1'b0;
        ok = busy;
        edges = 0;
        while (edges < 20) begin
            step();
            edges++;
            if (done) break;
            if (!busy || sum !== s0 || cout !== c0) ok = 1'b0;
        end
        s = sum;
        c = cout;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 0; a = 0; b = 0; cin = 0;
        start2 = 0; a2 = 0; b2 = 0; cin2 = 0;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            errors++;
            $display("FAIL reset8: got busy=%b done=%b cout=%b sum=%h required all 0",
                     busy, done, cout, sum);
        end
        checks++;
        if ({busy2, done2, cout2, sum2} !== 5'd0) begin
            errors++;
            $display("FAIL reset2: got busy=%b done=%b cout=%b sum=%h required all 0",
                     busy2, done2, cout2, sum2);
        end
    endtask

    task automatic test_basic();
        int edges; logic [7:0] s; logic c, ok;
        run8(8'h5A, 8'h3C, 1'b0, edges, s, c, ok);
        checks++;
        if (edges !== 8) begin
            errors++; $display("FAIL basic_latency: got %0d edges required 8", edges);
        end
        checks++;
        if (ok !== 1'b1) begin
            errors++; $display("FAIL basic_busy_hold: got %b required 1", ok);
        end
        checks++;
        if ({c, s} !== 9'h096) begin
            errors++; $display("FAIL basic_sum: got cout=%b sum=%h required cout=0 sum=96", c, s);
        end
    endtask

    task automatic test_carry();
        int edges; logic [7:0] s; logic c, ok;
        run8(8'hFF, 8'h01, 1'b0, edges, s, c, ok);
        checks++;
        if ({c, s} !== 9'h100 || edges !== 8) begin
            errors++;
            $display("FAIL carry_ff_01: got cout=%b sum=%h edges=%0d required 1 00 8", c, s, edges);
        end
        // Issued in the done cycle of the previous op: back-to-back.
        run8(8'h0F, 8'h00, 1'b1, edges, s, c, ok);
        checks++;
        if ({c, s} !== 9'h010 || edges !== 8 || ok !== 1'b1) begin
            errors++;
            $display("FAIL carry_cin: got cout=%b sum=%h edges=%0d ok=%b required 0 10 8 1",
                     c, s, edges, ok);
        end
        run8(8'hFF, 8'hFF, 1'b1, edges, s, c, ok);
        checks++;
        if ({c, s} !== 9'h1FF || edges !== 8) begin
            errors++;
            $display("FAIL carry_ff_ff: got cout=%b sum=%h edges=%0d required 1 ff 8", c, s, edges);
        end
    endtask

    task automatic test_back_to_back();
        int edges;
        logic ok;
        a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
        step();
        a = 8'h80; b = 8'h80;
        ok = busy;
        edges = 0;
        while (edges < 20) begin
            step(); edges++;
            if (done) break;
            if (!busy) ok = 1'b0;
        end
        checks++;
        if ({cout, sum} !== 9'h002 || edges !== 8 || ok !== 1'b1) begin
            errors++;
            $display("FAIL overlap_first: got cout=%b sum=%h edges=%0d busy_ok=%b required 0 02 8 1",
                     cout, sum, edges, ok);
        end
        // start is still high in the done cycle, so the 0x80 request is taken at this edge.
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("FAIL overlap_accept: got busy=%b required 1", busy);
        end
        edges = 0;
        while (edges < 20) begin
            step(); edges++;
            if (done) break;
        end
        checks++;
        if ({cout, sum} !== 9'h100 || edges !== 8) begin
            errors++;
            $display("FAIL overlap_second: got cout=%b sum=%h edges=%0d required 1 00 8",
                     cout, sum, edges);
        end
    endtask

    task automatic test_reset_mid_run();
        logic saw_done;
        int edges; logic [7:0] s; logic c, ok;
        run8(8'hFF, 8'hFF, 1'b1, edges, s, c, ok);
        a = 8'h55; b = 8'hAA; cin = 1'b0; start = 1'b1;
        step();
        start = 1'b0;
        repeat (4) step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cout, sum} !== 11'd0) begin
            errors++;
            $display("FAIL async_reset: got busy=%b done=%b cout=%b sum=%h required all 0",
                     busy, done, cout, sum);
        end
        #2 rst_n = 1'b1;
        saw_done = 1'b0;
        repeat (12) begin
            step();
            if (done || busy) saw_done = 1'b1;
        end
        checks++;
        if (saw_done !== 1'b0 || sum !== 8'h00 || cout !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got activity=%b sum=%h cout=%b required 0 00 0",
                     saw_done, sum, cout);
        end
    endtask

    task automatic test_exhaustive_w2();
        int n;
        logic [2:0] exp;
        int bad = 0;
        int lat_bad = 0;
        a2 = 2'd0; b2 = 2'd0; cin2 = 1'b0; start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int i = 0; i < 32; i++) begin
            exp = 3'({1'b0, 2'(i >> 3)}) + 3'({1'b0, 2'(i >> 1)}) + 3'(i & 1);
            n = 0;
            while (n < 10) begin
                step(); n++;
                if (done2) break;
            end
            if (n !== 2) lat_bad++;
            checks++;
            if ({cout2, sum2} !== exp) begin
                errors++; bad++;
                $display("FAIL w2_combo%0d: got %0d required %0d", i, {cout2, sum2}, exp);
            end
            if (i < 31) begin
                a2 = 2'((i + 1) >> 3); b2 = 2'((i + 1) >> 1); cin2 = 1'((i + 1) & 1);
                start2 = 1'b1;
                step();
                start2 = 1'b0;
            end
        end
        checks++;
        if (lat_bad !== 0) begin
            errors++; $display("FAIL w2_latency: got %0d late ops required 0", lat_bad);
        end
    endtask

    task automatic test_hold();
        int edges; logic [7:0] s; logic c, ok;
        logic moved = 1'b0;
        run8(8'h12, 8'h34, 1'b0, edges, s, c, ok);
        checks++;
        if ({c, s} !== 9'h046 || edges !== 8) begin
            errors++;
            $display("FAIL hold_op: got cout=%b sum=%h edges=%0d required 0 46 8", c, s, edges);
        end
        a = 8'hAA; b = 8'hBB; cin = 1'b1;
        repeat (20) begin
            step();
            if (sum !== 8'h46 || cout !== 1'b0 || busy || done) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++; $display("FAIL hold_stable: got change=%b required 0", moved);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_carry();
        test_reset_mid_run();
        test_exhaustive_w2();
        test_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
